// File: rtl/flash_read_sched.sv
// Two-requester round-robin burst scheduler in front of a single-byte flash reader.
// Optional build macro FLASH_SCHED_TIMEOUT_EN adds a rd_ready timeout with an err pulse.
module flash_read_sched #(
    parameter logic [23:0] BASE_ADDR = 24'h400000,
    parameter logic [23:0] WINDOW    = 24'd26,
    parameter int unsigned HOLDOFF   = 48,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    output logic [1:0]  gnt,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic [1:0]  dout_ready,
    output logic [1:0]  done,
    output logic        err,
    output logic        rd_read,
    output logic [23:0] rd_addr,
    input  logic        rd_ready,
    input  logic [7:0]  rd_data
);
    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int unsigned HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [23:0] LIMIT = BASE_ADDR + WINDOW;

    logic [2:0]    state;
    logic [HW-1:0] hcnt;
    logic          last;     // requester served most recently
    logic          sel;      // index of the granted requester
    logic [23:0]   cur;
    logic [8:0]    rem;
    logic          pick;
    logic          accept;
    logic [23:0]   cur_inc;
    logic [23:0]   cur_next;
    logic          timeout_hit;

    always_comb begin
        if (req[0] && req[1]) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
        accept   = sel ? dout_ready[1] : dout_ready[0];
        cur_inc  = cur + 24'd1;
        cur_next = (cur_inc >= LIMIT) ? BASE_ADDR : cur_inc;
    end

`ifdef FLASH_SCHED_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // WAIT lasts TIMEOUT-1 cycles, so err/done land TIMEOUT cycles after rd_read
    assign timeout_hit = (state == S_WAIT) && !rd_ready && (tcnt == TW'(TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HOLD;
            hcnt       <= '0;
            last       <= 1'b1;
            sel        <= 1'b0;
            cur        <= '0;
            rem        <= '0;
            gnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hcnt == HW'(HOLDOFF - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                S_IDLE: begin
                    if (req != 2'b00) begin
                        sel   <= pick;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        cur   <= pick ? addr1 : addr0;
                        rem   <= pick ? {len1 == 8'd0, len1} : {len0 == 8'd0, len0};
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_ready) begin
                        dout       <= rd_data;
                        dout_valid <= 1'b1;
                        state      <= S_DELIVER;
                    end else if (timeout_hit) begin
                        state <= S_DONE;
                    end
                end
                S_DELIVER: begin
                    // a dropped req only ends the burst once the byte in flight is taken
                    if (accept) begin
                        dout_valid <= 1'b0;
                        rem        <= rem - 9'd1;
                        cur        <= cur_next;
                        state      <= (rem == 9'd1 || !req[sel]) ? S_DONE : S_ISSUE;
                    end
                end
                S_DONE: begin
                    gnt   <= '0;
                    last  <= sel;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

    assign rd_read = (state == S_ISSUE);
    assign rd_addr = cur;
    assign done    = (state == S_DONE) ? gnt : 2'b00;

endmodule
